// File: rtl/dsram_like_bridge_pkg.sv
// rtl/dsram_like_bridge_pkg.sv - shared state enum and bus size codes for the sram-like data bridge
package dsram_like_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dsram_like_bridge_if.sv
// rtl/dsram_like_bridge_if.sv - sram-like data bus between the bridge (master) and memory (slave)
interface dsram_like_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dsram_like_bridge_size_dec.sv
// rtl/dsram_like_bridge_size_dec.sv - byte-enable to bus size / aligned low address decode
module dsram_size_dec
  import dsram_like_bridge_pkg::*;
(
  input  logic [3:0] wen,
  input  logic [1:0] addr_lo,
  output logic [1:0] size,
  output logic [1:0] aligned_lo,
  output logic       wr
);

  // The lane pattern alone determines the bus address low bits, so the
  // incoming low bits are deliberately not consulted.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo;

  assign wr = |wen;

  // Map the byte-enable pattern to size and the address of its lowest lane
  always_comb begin
    size       = SIZE_WORD;
    aligned_lo = 2'b00;
    unique case (wen)
      4'b0001: begin size = SIZE_BYTE; aligned_lo = 2'b00; end
      4'b0010: begin size = SIZE_BYTE; aligned_lo = 2'b01; end
      4'b0100: begin size = SIZE_BYTE; aligned_lo = 2'b10; end
      4'b1000: begin size = SIZE_BYTE; aligned_lo = 2'b11; end
      4'b0011: begin size = SIZE_HALF; aligned_lo = 2'b00; end
      4'b1100: begin size = SIZE_HALF; aligned_lo = 2'b10; end
      default: begin size = SIZE_WORD; aligned_lo = 2'b00; end
    endcase
  end

endmodule

// File: rtl/dsram_like_bridge.sv
// rtl/dsram_like_bridge.sv - stalls the CPU data port across one sram-like bus transaction
module dsram_like_bridge
  import dsram_like_bridge_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_en,
  input  logic [3:0]                cpu_wen,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic                      cpu_longest_stall,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_stall,
  dsram_like_bridge_if.master       bus
);

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic [31:0] rdata_q;

  logic [1:0]  dec_size;
  logic [1:0]  dec_lo;
  logic        dec_wr;

  logic        accept;

  dsram_size_dec u_size_dec (
    .wen        (cpu_wen),
    .addr_lo    (cpu_addr[1:0]),
    .size       (dec_size),
    .aligned_lo (dec_lo),
    .wr         (dec_wr)
  );

  // A new CPU access is only taken from IDLE; inputs elsewhere are ignored
  assign accept = (state == IDLE) && cpu_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one outstanding transaction, held in DONE while the pipe is frozen
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (cpu_en)             state_next = ADDR;
      ADDR: if (bus.data_addr_ok)   state_next = DATA;
      DATA: if (bus.data_data_ok)   state_next = DONE;
      DONE: if (!cpu_longest_stall) state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // FSM outputs: request only in ADDR, stall until the response has landed
  always_comb begin
    bus.data_req = (state == ADDR);
    cpu_stall    = !rst && (accept || (state == ADDR) || (state == DATA));
  end

  // Request capture on acceptance and read-data capture on the response beat
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        addr_q  <= {cpu_addr[31:2], dec_lo};
        wdata_q <= cpu_wdata;
        size_q  <= dec_size;
        wr_q    <= dec_wr;
      end
      if ((state == DATA) && bus.data_data_ok && !wr_q) begin
        rdata_q <= bus.data_rdata;
      end
    end
  end

  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign cpu_rdata      = rdata_q;

endmodule

// File: tb/tb_dsram_like_bridge.sv
// tb/tb_dsram_like_bridge.sv - directed self-checking bench for dsram_like_bridge
module tb_dsram_like_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_longest_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  int total;
  int bad;

  dsram_like_bridge_if bus ();

  dsram_like_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_en            (cpu_en),
    .cpu_wen           (cpu_wen),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_longest_stall (cpu_longest_stall),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .bus               (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before checking
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    cpu_en = 1'b0;
    cpu_wen = 4'b0000;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_en = 1'b1;
    cpu_wen = 4'b1111;
    cpu_addr = 32'h0000_0040;
    tick();
    tick();
    settle();
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", cpu_stall); end
    total++; if (bus.data_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", bus.data_req); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    total++; if (bus.data_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.data_addr); end
    total++; if (bus.data_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.data_wdata); end
    total++; if ({bus.data_wr, bus.data_size} !== 3'b000) begin bad++; $display("FAIL reset_wr_size got=%b exp=000", {bus.data_wr, bus.data_size}); end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_zero_wait();
    // cycle 0
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_1004;
    settle();
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_c0 got=%0b exp=1", cpu_stall); end
    // cycle 1
    tick();
    cpu_en = 1'b0; bus.data_addr_ok = 1'b1;
    settle();
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_c1 got=%0b exp=1", cpu_stall); end
    total++; if (bus.data_req !== 1'b1) begin bad++; $display("FAIL rd_req_c1 got=%0b exp=1", bus.data_req); end
    total++; if (bus.data_addr !== 32'h0000_1004) begin bad++; $display("FAIL rd_addr got=%h exp=00001004", bus.data_addr); end
    total++; if ({bus.data_wr, bus.data_size} !== 3'b010) begin bad++; $display("FAIL rd_wr_size got=%b exp=010", {bus.data_wr, bus.data_size}); end
    // cycle 2
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
    settle();
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_c2 got=%0b exp=1", cpu_stall); end
    total++; if (bus.data_req !== 1'b0) begin bad++; $display("FAIL rd_req_c2 got=%0b exp=0", bus.data_req); end
    // cycle 3
    tick();
    idle_inputs();
    settle();
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_c3 got=%0b exp=0", cpu_stall); end
    total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", cpu_rdata); end
    tick();
  endtask

  task automatic test_byte_store();
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h00AB_0000;
    tick();
    cpu_en = 1'b0; cpu_wen = 4'b0000; bus.data_addr_ok = 1'b1;
    settle();
    total++; if (bus.data_wr !== 1'b1) begin bad++; $display("FAIL bs_wr got=%0b exp=1", bus.data_wr); end
    total++; if (bus.data_size !== 2'd0) begin bad++; $display("FAIL bs_size got=%0d exp=0", bus.data_size); end
    total++; if (bus.data_addr !== 32'h0000_2002) begin bad++; $display("FAIL bs_addr got=%h exp=00002002", bus.data_addr); end
    total++; if (bus.data_wdata !== 32'h00AB_0000) begin bad++; $display("FAIL bs_wdata got=%h exp=00ab0000", bus.data_wdata); end
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1111_1111;
    tick();
    idle_inputs();
    settle();
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL bs_stall_done got=%0b exp=0", cpu_stall); end
    total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bs_rdata_kept got=%h exp=deadbeef", cpu_rdata); end
    tick();
  endtask

  task automatic test_addr_wait();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_3008;
    tick();
    for (int i = 0; i < 5; i++) begin
      cpu_addr = 32'h0000_9000 + 32'(i * 4);
      cpu_wen = 4'b1111;
      settle();
      total++; if (bus.data_req !== 1'b1) begin bad++; $display("FAIL aw_req[%0d] got=%0b exp=1", i, bus.data_req); end
      total++; if (bus.data_addr !== 32'h0000_3008) begin bad++; $display("FAIL aw_addr[%0d] got=%h exp=00003008", i, bus.data_addr); end
      total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL aw_stall[%0d] got=%0b exp=1", i, cpu_stall); end
      tick();
    end
    cpu_en = 1'b0; bus.data_addr_ok = 1'b1;
    settle();
    total++; if (bus.data_wr !== 1'b0) begin bad++; $display("FAIL aw_wr got=%0b exp=0", bus.data_wr); end
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
    tick();
    idle_inputs();
    settle();
    total++; if (cpu_rdata !== 32'h1234_5678) begin bad++; $display("FAIL aw_rdata got=%h exp=12345678", cpu_rdata); end
    tick();
  endtask

  task automatic test_longest_stall();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_4000;
    tick();
    cpu_en = 1'b0; bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
    tick();
    bus.data_data_ok = 1'b0;
    cpu_longest_stall = 1'b1; cpu_en = 1'b1; cpu_addr = 32'h0000_5004;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL ls_stall[%0d] got=%0b exp=0", i, cpu_stall); end
      total++; if (bus.data_req !== 1'b0) begin bad++; $display("FAIL ls_req[%0d] got=%0b exp=0", i, bus.data_req); end
      total++; if (cpu_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL ls_rdata[%0d] got=%h exp=cafef00d", i, cpu_rdata); end
      tick();
    end
    cpu_longest_stall = 1'b0;
    settle();
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL ls_release_stall got=%0b exp=0", cpu_stall); end
    tick();
    settle();
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL ls_idle_accept got=%0b exp=1", cpu_stall); end
    tick();
    cpu_en = 1'b0; bus.data_addr_ok = 1'b1;
    settle();
    total++; if (bus.data_req !== 1'b1) begin bad++; $display("FAIL ls_new_req got=%0b exp=1", bus.data_req); end
    total++; if (bus.data_addr !== 32'h0000_5004) begin bad++; $display("FAIL ls_new_addr got=%h exp=00005004", bus.data_addr); end
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BAD_CAFE;
    tick();
    idle_inputs();
    settle();
    total++; if (cpu_rdata !== 32'h0BAD_CAFE) begin bad++; $display("FAIL ls_new_rdata got=%h exp=0badcafe", cpu_rdata); end
    tick();
  endtask

  task automatic test_rst_in_data();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_6000;
    tick();
    cpu_en = 1'b0; bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    rst = 1'b1;
    settle();
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rs_stall_in_rst got=%0b exp=0", cpu_stall); end
    tick();
    rst = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
    settle();
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rs_rdata_clr got=%h exp=0", cpu_rdata); end
    total++; if (bus.data_addr !== 32'h0) begin bad++; $display("FAIL rs_addr_clr got=%h exp=0", bus.data_addr); end
    tick();
    bus.data_data_ok = 1'b0;
    settle();
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rs_stray_rdata got=%h exp=0", cpu_rdata); end
    total++; if (bus.data_req !== 1'b0) begin bad++; $display("FAIL rs_stray_req got=%0b exp=0", bus.data_req); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rs_stray_stall got=%0b exp=0", cpu_stall); end
    tick();
    settle();
    total++; if (bus.data_req !== 1'b0) begin bad++; $display("FAIL rs_still_idle got=%0b exp=0", bus.data_req); end
    tick();
  endtask

  task automatic test_half_and_illegal();
    logic [3:0]  wens  [4] = '{4'b1100, 4'b0101, 4'b0011, 4'b1000};
    logic [31:0] addrs [4] = '{32'h10, 32'h23, 32'h31, 32'h40};
    logic [31:0] exp_a [4] = '{32'h12, 32'h20, 32'h30, 32'h43};
    logic [1:0]  exp_s [4] = '{2'd1, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 4; i++) begin
      cpu_en = 1'b1; cpu_wen = wens[i]; cpu_addr = addrs[i]; cpu_wdata = 32'h5A5A_0000 + 32'(i);
      tick();
      cpu_en = 1'b0; bus.data_addr_ok = 1'b1;
      settle();
      total++; if (bus.data_size !== exp_s[i]) begin bad++; $display("FAIL hi_size[%0d] got=%0d exp=%0d", i, bus.data_size, exp_s[i]); end
      total++; if (bus.data_addr !== exp_a[i]) begin bad++; $display("FAIL hi_addr[%0d] got=%h exp=%h", i, bus.data_addr, exp_a[i]); end
      total++; if (bus.data_wr !== 1'b1) begin bad++; $display("FAIL hi_wr[%0d] got=%0b exp=1", i, bus.data_wr); end
      tick();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_7777;
      tick();
      idle_inputs();
      settle();
      total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL hi_rdata[%0d] got=%h exp=0", i, cpu_rdata); end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    cpu_en = 1'b0;
    cpu_wen = 4'b0000;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    cpu_longest_stall = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata = 32'h0;
    #2;
    test_reset();
    test_read_zero_wait();
    test_byte_store();
    test_addr_wait();
    test_longest_stall();
    test_rst_in_data();
    test_half_and_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
